// File: rtl/minisrc_ctrl_pkg.sv
// Shared constants for the Mini-SRC control sequencer: state codes, opcodes,
// IR field positions and the default ALU add code.
package minisrc_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OPC_W   = 5;

  // State codes double as the debug step value.
  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_T7    = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd15;

  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  // IR field positions
  localparam int unsigned IR_OPC_HI = 31;
  localparam int unsigned IR_OPC_LO = 27;
  localparam int unsigned IR_RA_HI  = 26;
  localparam int unsigned IR_RA_LO  = 23;
  localparam int unsigned IR_RB_HI  = 22;
  localparam int unsigned IR_RB_LO  = 19;
  localparam int unsigned IR_C_HI   = 18;
  localparam int unsigned IR_C_LO   = 0;

  localparam logic [4:0] OP_ADD_DEFAULT = 5'b00100;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait-state counter: loads MEM_WAIT, decrements (saturating at 0),
// done is high when the count reads 0.
// Ports: Clock, Clear (async active-low), load, dec, done.
module ctrl_wait_timer #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic Clock,
  input  logic Clear,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int unsigned CNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(MEM_WAIT);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/ldst_control_unit.sv
// Hardwired Moore control sequencer for the Mini-SRC datapath (ld/ldi/st/nop/halt).
// Inputs: Clock, Clear (async active-low), IR, CON_Out (reserved), Stop.
// Outputs: register load/drive enables, select/memory/PC strobes, OP, Run,
// illegal_op (T3 pulse), step (state code for debug).
module ldst_control_unit
  import minisrc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter logic [4:0]  OP_ADD   = OP_ADD_DEFAULT
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_Out,
  input  logic        Stop,
  output logic PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin,
  output logic PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout,
  output logic Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, CON_In, GLR,
  output logic [4:0]  OP,
  output logic        Run,
  output logic        illegal_op,
  output logic [3:0]  step
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [OPC_W-1:0]   opc_q, opc_d, opc_c;
  logic               to_t0_c;
  logic               wait_done;
  logic               unused_ir;

  // Only the opcode is needed here; register fields are consumed by the datapath.
  assign unused_ir = ^{IR[IR_RA_HI:IR_RA_LO], IR[IR_RB_HI:IR_RB_LO],
                       IR[IR_C_HI:IR_C_LO], CON_Out};

  // The datapath IR is written at the end of T2, so the opcode is read live in
  // T3 and held from then on; the stale IR at the T2->T3 edge is never used.
  assign opc_c = (state_q == S_T3) ? IR[IR_OPC_HI:IR_OPC_LO] : opc_q;
  assign opc_d = opc_c;

  // Reload the wait counter on every state change so it is fresh on entry.
  ctrl_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .Clock (Clock),
    .Clear (Clear),
    .load  (state_d != state_q),
    .dec   (1'b1),
    .done  (wait_done)
  );

  // Next-state: to_t0_c marks an instruction boundary, where Stop is honoured
  always_comb begin
    state_d = state_q;
    to_t0_c = 1'b0;
    case (state_q)
      S_RESET: to_t0_c = 1'b1;
      S_T0:    state_d = S_T1;
      S_T1:    if (wait_done) state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3: begin
        case (opc_c)
          OPC_LD, OPC_LDI, OPC_ST: state_d = S_T4;
          OPC_HALT:                state_d = S_HALT;
          default:                 to_t0_c = 1'b1;
        endcase
      end
      S_T4:    state_d = S_T5;
      S_T5: begin
        if (opc_c == OPC_LDI) to_t0_c = 1'b1;
        else                  state_d = S_T6;
      end
      S_T6: begin
        if (opc_c != OPC_LD || wait_done) state_d = S_T7;
      end
      S_T7: begin
        if (opc_c != OPC_ST || wait_done) to_t0_c = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
    if (to_t0_c) state_d = Stop ? S_HALT : S_T0;
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= S_RESET;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

  // Moore output decode
  always_comb begin
    {PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin} = '0;
    {PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout}        = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, CON_In, GLR}    = '0;
    OP         = '0;
    illegal_op = 1'b0;
    step       = state_q;
    Run        = (state_q != S_RESET) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      S_T1: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (opc_c)
          OPC_LD, OPC_LDI, OPC_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          OPC_NOP, OPC_HALT: ;
          default: illegal_op = 1'b1;
        endcase
      end
      S_T4: begin Cout = 1'b1; OP = OP_ADD; ZHighin = 1'b1; ZLowin = 1'b1; end
      S_T5: begin
        ZLowout = 1'b1;
        if (opc_c == OPC_LDI) begin Gra = 1'b1; Rin = 1'b1; end
        else                  MARin = 1'b1;
      end
      S_T6: begin
        if (opc_c == OPC_LD) begin Read = 1'b1; MDRin = 1'b1; end
        else                 begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
      end
      S_T7: begin
        MDRout = 1'b1;
        if (opc_c == OPC_LD) begin Gra = 1'b1; Rin = 1'b1; end
        else                 Write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldst_control_unit.sv
// Directed bench for ldst_control_unit: one instance with single-cycle memory
// (dut_a) and one with two extra wait cycles (dut_b), sharing all inputs.
module tb_ldst_control_unit;

  logic        Clock = 1'b0;
  logic        Clear, Stop, CON_Out;
  logic [31:0] IR;

  always #5 Clock = ~Clock;

  // Strobe vector bit order
  // 0 PCin 1 IRin 2 HIin 3 LOin 4 ZHighin 5 ZLowin 6 MARin 7 MDRin 8 OutPort 9 Yin
  // 10 PCout 11 HIout 12 LOout 13 ZHighout 14 ZLowout 15 InPort 16 MDRout 17 Cout
  // 18 Gra 19 Grb 20 Grc 21 Rin 22 Rout 23 BAout 24 Read 25 Write 26 IncPC 27 CON_In 28 GLR
  wire [28:0] sa, sb;
  wire [4:0]  opa, opb;
  wire        runa, runb, illa, illb;
  wire [3:0]  stpa, stpb;

  localparam logic [28:0] M_NONE  = 29'd0;
  localparam logic [28:0] M_T0    = (29'd1 << 10) | (29'd1 << 6)  | (29'd1 << 26);
  localparam logic [28:0] M_RD    = (29'd1 << 24) | (29'd1 << 7);
  localparam logic [28:0] M_T2    = (29'd1 << 16) | (29'd1 << 1);
  localparam logic [28:0] M_EA3   = (29'd1 << 19) | (29'd1 << 23) | (29'd1 << 9);
  localparam logic [28:0] M_EA4   = (29'd1 << 17) | (29'd1 << 4)  | (29'd1 << 5);
  localparam logic [28:0] M_MAR5  = (29'd1 << 14) | (29'd1 << 6);
  localparam logic [28:0] M_LDI5  = (29'd1 << 14) | (29'd1 << 18) | (29'd1 << 21);
  localparam logic [28:0] M_ST6   = (29'd1 << 18) | (29'd1 << 22) | (29'd1 << 7);
  localparam logic [28:0] M_ST7   = (29'd1 << 16) | (29'd1 << 25);
  localparam logic [28:0] M_LD7   = (29'd1 << 16) | (29'd1 << 18) | (29'd1 << 21);
  localparam logic [4:0]  ADD     = 5'b00100;

  ldst_control_unit #(.MEM_WAIT(0)) dut_a (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_Out(CON_Out), .Stop(Stop),
    .PCin(sa[0]), .IRin(sa[1]), .HIin(sa[2]), .LOin(sa[3]), .ZHighin(sa[4]),
    .ZLowin(sa[5]), .MARin(sa[6]), .MDRin(sa[7]), .OutPort(sa[8]), .Yin(sa[9]),
    .PCout(sa[10]), .HIout(sa[11]), .LOout(sa[12]), .ZHighout(sa[13]),
    .ZLowout(sa[14]), .InPort(sa[15]), .MDRout(sa[16]), .Cout(sa[17]),
    .Gra(sa[18]), .Grb(sa[19]), .Grc(sa[20]), .Rin(sa[21]), .Rout(sa[22]),
    .BAout(sa[23]), .Read(sa[24]), .Write(sa[25]), .IncPC(sa[26]),
    .CON_In(sa[27]), .GLR(sa[28]),
    .OP(opa), .Run(runa), .illegal_op(illa), .step(stpa)
  );

  ldst_control_unit #(.MEM_WAIT(2)) dut_b (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_Out(CON_Out), .Stop(Stop),
    .PCin(sb[0]), .IRin(sb[1]), .HIin(sb[2]), .LOin(sb[3]), .ZHighin(sb[4]),
    .ZLowin(sb[5]), .MARin(sb[6]), .MDRin(sb[7]), .OutPort(sb[8]), .Yin(sb[9]),
    .PCout(sb[10]), .HIout(sb[11]), .LOout(sb[12]), .ZHighout(sb[13]),
    .ZLowout(sb[14]), .InPort(sb[15]), .MDRout(sb[16]), .Cout(sb[17]),
    .Gra(sb[18]), .Grb(sb[19]), .Grc(sb[20]), .Rin(sb[21]), .Rout(sb[22]),
    .BAout(sb[23]), .Read(sb[24]), .Write(sb[25]), .IncPC(sb[26]),
    .CON_In(sb[27]), .GLR(sb[28]),
    .OP(opb), .Run(runb), .illegal_op(illb), .step(stpb)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare every output of the selected instance right now.
  task automatic sample(input bit use_b, input string tag, input logic [3:0] es,
                        input logic [28:0] em, input logic [4:0] eop, input logic eill);
    logic [28:0] m;
    logic [4:0]  op;
    logic [3:0]  st;
    logic        run, ill, erun;
    m    = use_b ? sb   : sa;
    op   = use_b ? opb  : opa;
    st   = use_b ? stpb : stpa;
    run  = use_b ? runb : runa;
    ill  = use_b ? illb : illa;
    erun = (es != 4'd0) && (es != 4'd15);
    check_eq($sformatf("%s.step", tag),    32'(st),  32'(es));
    check_eq($sformatf("%s.strobes", tag), 32'(m),   32'(em));
    check_eq($sformatf("%s.op", tag),      32'(op),  32'(eop));
    check_eq($sformatf("%s.run", tag),     32'(run), 32'(erun));
    check_eq($sformatf("%s.illegal", tag), 32'(ill), 32'(eill));
  endtask

  // Advance to the next falling edge and check.
  task automatic cyc(input bit use_b, input string tag, input logic [3:0] es,
                     input logic [28:0] em, input logic [4:0] eop, input logic eill);
    @(negedge Clock);
    sample(use_b, tag, es, em, eop, eill);
  endtask

  // Hold Clear low, check idle outputs, release on a falling edge.
  task automatic do_reset(input string tag);
    @(negedge Clock);
    Clear = 1'b0;
    repeat (2) @(negedge Clock);
    sample(1'b0, {tag, ".a"}, 4'd0, M_NONE, 5'd0, 1'b0);
    sample(1'b1, {tag, ".b"}, 4'd0, M_NONE, 5'd0, 1'b0);
    Clear = 1'b1;
  endtask

  // Read and Write must never be high together on either instance.
  always @(negedge Clock) begin
    if (Clear === 1'b1) begin
      check_eq("rw_excl_a", 32'(sa[24] & sa[25]), 32'd0);
      check_eq("rw_excl_b", 32'(sb[24] & sb[25]), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Clear = 1'b0; Stop = 1'b0; CON_Out = 1'b0; IR = 32'h0;

    // st, single-cycle memory
    IR = 32'h12200090;
    do_reset("st_rst");
    cyc(0, "st_t0", 4'd1, M_T0,   5'd0, 1'b0);
    cyc(0, "st_t1", 4'd2, M_RD,   5'd0, 1'b0);
    cyc(0, "st_t2", 4'd3, M_T2,   5'd0, 1'b0);
    cyc(0, "st_t3", 4'd4, M_EA3,  5'd0, 1'b0);
    cyc(0, "st_t4", 4'd5, M_EA4,  ADD,  1'b0);
    cyc(0, "st_t5", 4'd6, M_MAR5, 5'd0, 1'b0);
    cyc(0, "st_t6", 4'd7, M_ST6,  5'd0, 1'b0);
    cyc(0, "st_t7", 4'd8, M_ST7,  5'd0, 1'b0);
    cyc(0, "st_nx", 4'd1, M_T0,   5'd0, 1'b0);

    // ld R2,$10(R3) with two wait cycles
    IR = 32'h01180010;
    do_reset("ld_rst");
    cyc(1, "ld_t0", 4'd1, M_T0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1, $sformatf("ld_t1_%0d", i), 4'd2, M_RD, 5'd0, 1'b0);
    cyc(1, "ld_t2", 4'd3, M_T2,   5'd0, 1'b0);
    cyc(1, "ld_t3", 4'd4, M_EA3,  5'd0, 1'b0);
    cyc(1, "ld_t4", 4'd5, M_EA4,  ADD,  1'b0);
    cyc(1, "ld_t5", 4'd6, M_MAR5, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1, $sformatf("ld_t6_%0d", i), 4'd7, M_RD, 5'd0, 1'b0);
    cyc(1, "ld_t7", 4'd8, M_LD7, 5'd0, 1'b0);
    cyc(1, "ld_nx", 4'd1, M_T0,  5'd0, 1'b0);

    // ldi R1,5
    IR = 32'h08800005;
    do_reset("ldi_rst");
    cyc(0, "ldi_t0", 4'd1, M_T0,   5'd0, 1'b0);
    cyc(0, "ldi_t1", 4'd2, M_RD,   5'd0, 1'b0);
    cyc(0, "ldi_t2", 4'd3, M_T2,   5'd0, 1'b0);
    cyc(0, "ldi_t3", 4'd4, M_EA3,  5'd0, 1'b0);
    cyc(0, "ldi_t4", 4'd5, M_EA4,  ADD,  1'b0);
    cyc(0, "ldi_t5", 4'd6, M_LDI5, 5'd0, 1'b0);
    cyc(0, "ldi_nx", 4'd1, M_T0,   5'd0, 1'b0);

    // halt: absorbing until Clear
    IR = 32'hD8000000;
    do_reset("hlt_rst");
    cyc(0, "hlt_t0", 4'd1, M_T0,   5'd0, 1'b0);
    cyc(0, "hlt_t1", 4'd2, M_RD,   5'd0, 1'b0);
    cyc(0, "hlt_t2", 4'd3, M_T2,   5'd0, 1'b0);
    cyc(0, "hlt_t3", 4'd4, M_NONE, 5'd0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(0, $sformatf("hlt_%0d", i), 4'd15, M_NONE, 5'd0, 1'b0);
    @(negedge Clock);
    Clear = 1'b0;
    #1 sample(0, "hlt_clr", 4'd0, M_NONE, 5'd0, 1'b0);
    @(negedge Clock);
    sample(0, "hlt_rst", 4'd0, M_NONE, 5'd0, 1'b0);
    Clear = 1'b1;
    cyc(0, "hlt_restart", 4'd1, M_T0, 5'd0, 1'b0);

    // Clear asserted mid-T4 of st
    IR = 32'h12200090;
    do_reset("stc_rst");
    cyc(0, "stc_t0", 4'd1, M_T0,  5'd0, 1'b0);
    cyc(0, "stc_t1", 4'd2, M_RD,  5'd0, 1'b0);
    cyc(0, "stc_t2", 4'd3, M_T2,  5'd0, 1'b0);
    cyc(0, "stc_t3", 4'd4, M_EA3, 5'd0, 1'b0);
    cyc(0, "stc_t4", 4'd5, M_EA4, ADD,  1'b0);
    Clear = 1'b0;
    #1 sample(0, "stc_clr", 4'd0, M_NONE, 5'd0, 1'b0);
    @(negedge Clock);
    Clear = 1'b1;
    cyc(0, "stc_t0b", 4'd1, M_T0, 5'd0, 1'b0);
    cyc(0, "stc_t1b", 4'd2, M_RD, 5'd0, 1'b0);

    // unsupported opcode 00111
    IR = 32'h38000000;
    do_reset("ill_rst");
    cyc(0, "ill_t0", 4'd1, M_T0,   5'd0, 1'b0);
    cyc(0, "ill_t1", 4'd2, M_RD,   5'd0, 1'b0);
    cyc(0, "ill_t2", 4'd3, M_T2,   5'd0, 1'b0);
    cyc(0, "ill_t3", 4'd4, M_NONE, 5'd0, 1'b1);
    cyc(0, "ill_nx", 4'd1, M_T0,   5'd0, 1'b0);

    // nop
    IR = 32'hD0000000;
    do_reset("nop_rst");
    cyc(0, "nop_t0", 4'd1, M_T0,   5'd0, 1'b0);
    cyc(0, "nop_t1", 4'd2, M_RD,   5'd0, 1'b0);
    cyc(0, "nop_t2", 4'd3, M_T2,   5'd0, 1'b0);
    cyc(0, "nop_t3", 4'd4, M_NONE, 5'd0, 1'b0);
    cyc(0, "nop_nx", 4'd1, M_T0,   5'd0, 1'b0);

    // Stop raised in T5 of ldi: completes, then HALT
    IR = 32'h08800005;
    do_reset("stp_rst");
    cyc(0, "stp_t0", 4'd1, M_T0,   5'd0, 1'b0);
    cyc(0, "stp_t1", 4'd2, M_RD,   5'd0, 1'b0);
    cyc(0, "stp_t2", 4'd3, M_T2,   5'd0, 1'b0);
    cyc(0, "stp_t3", 4'd4, M_EA3,  5'd0, 1'b0);
    cyc(0, "stp_t4", 4'd5, M_EA4,  ADD,  1'b0);
    cyc(0, "stp_t5", 4'd6, M_LDI5, 5'd0, 1'b0);
    Stop = 1'b1;
    cyc(0, "stp_halt0", 4'd15, M_NONE, 5'd0, 1'b0);
    Stop = 1'b0;
    cyc(0, "stp_halt1", 4'd15, M_NONE, 5'd0, 1'b0);

    @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
